tdc_shot_ctrl: RTL and testbench

//  Sequencer in front of the TDC core: fires TDC start pulses, programs range, waits for end-of-range INT,

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_shot_ctrl_if.sv | 24 ++
 rtl/tdc_int_sync.sv | 13 +
 rtl/tdc_shot_ctrl.sv | 150 +++++++++++++++
 tb/tb_tdc_shot_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared widths and one-hot sequencer states for the TDC shot controller.
package tdc_pkg;
   localparam int TOF_W = 10;
   localparam int INT_W = 5;
   localparam int RANGE_W = 15;
   localparam int HITS_W = 10;
   typedef enum logic [6:0] {
      S_IDLE  = 7'b0000001,
      S_ARM   = 7'b0000010,
      S_START = 7'b0000100,
      S_WAIT  = 7'b0001000,
      S_DRAIN = 7'b0010000,
      S_END   = 7'b0100000,
      S_EMIT  = 7'b1000000
   } state_e;
   function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/tdc_shot_ctrl_if.sv
// tdc_shot_ctrl_if: TDC core stream plus pixel result port; master is the controller.
interface tdc_shot_ctrl_if;
   import tdc_pkg::*;
   logic               tdc_start;
   logic [RANGE_W-1:0] tdc_range;
   logic [TOF_W-1:0]   tdc_odata;
   logic [INT_W-1:0]   tdc_oint;
   logic               tdc_olast;
   logic               tdc_ovalid;
   logic               tdc_oready;
   logic               m_valid;
   logic               m_ready;
   logic [TOF_W-1:0]   m_tof;
   logic [INT_W-1:0]   m_int;
   logic [HITS_W-1:0]  m_hits;
   modport master (
      output tdc_start, tdc_range, tdc_oready, m_valid, m_tof, m_int, m_hits,
      input  tdc_odata, tdc_oint, tdc_olast, tdc_ovalid, m_ready
   );
   modport slave (
      input  tdc_start, tdc_range, tdc_oready, m_valid, m_tof, m_int, m_hits,
      output tdc_odata, tdc_oint, tdc_olast, tdc_ovalid, m_ready
   );
endinterface

// File: rtl/tdc_int_sync.sv
// tdc_int_sync: two-flop synchronizer with rising-edge detect, one clk pulse per edge.
module tdc_int_sync (
   input  logic clk,
   input  logic rst,
   input  logic a_i,
   output logic p_o
);
   logic [2:0] s_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) s_q <= '0;
      else s_q <= {s_q[1:0], a_i};
   assign p_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/tdc_shot_ctrl.sv
// tdc_shot_ctrl: shot sequencer keeping per-pixel max-intensity return over cfg_shots shots.
// Define TDC_SHOT_CTRL_TIMEOUT_EN to abort a shot that never sees INT and flag err_tmo_o.
module tdc_shot_ctrl
   import tdc_pkg::*;
#(
   parameter int START_W   = 2,
   parameter int GUARD     = 4,
   parameter int DRAIN_WIN = 8,
   parameter int TMO_CYC   = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [7:0]         cfg_shots_i,
   input  logic [RANGE_W-1:0] cfg_range_i,
   input  logic               tdc_int_i,
   tdc_shot_ctrl_if.master    bus,
   output logic               busy_o,
   output logic               err_tmo_o
);
   localparam int CNT_W = $clog2(TMO_CYC) + 1;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         shot_q, shot_d;
   logic [HITS_W-1:0]  hits_q, hits_d, m_hits_q, m_hits_d;
   logic [TOF_W-1:0]   best_tof_q, best_tof_d, m_tof_q, m_tof_d;
   logic [INT_W-1:0]   best_int_q, best_int_d, m_int_q, m_int_d;
   logic [RANGE_W-1:0] range_q, range_d;
   logic               got_q, got_d, start_q, start_d, m_valid_q, m_valid_d, err_q, err_d;
   logic               int_p, hs, clr;
   logic [7:0]         shots_eff;
   tdc_int_sync u_sync (.clk(clk), .rst(rst), .a_i(tdc_int_i), .p_o(int_p));
   assign bus.tdc_oready = state_q == S_DRAIN;
   assign hs = bus.tdc_ovalid & bus.tdc_oready;
   assign shots_eff = (cfg_shots_i == '0) ? 8'd1 : cfg_shots_i;
   assign bus.tdc_start = start_q;
   assign bus.tdc_range = range_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_tof = m_tof_q;
   assign bus.m_int = m_int_q;
   assign bus.m_hits = m_hits_q;
   assign busy_o = state_q != S_IDLE;
   assign err_tmo_o = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      shot_d = shot_q;
      hits_d = hits_q;
      best_tof_d = best_tof_q;
      best_int_d = best_int_q;
      range_d = range_q;
      got_d = got_q;
      m_valid_d = m_valid_q;
      m_tof_d = m_tof_q;
      m_int_d = m_int_q;
      m_hits_d = m_hits_q;
      err_d = err_q;
      clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = en_i ? S_ARM : S_IDLE;
            clr = en_i;
         end
         S_ARM: begin
            if (cnt_q == '0) range_d = cfg_range_i;
            if (cnt_q == CNT_W'(GUARD - 1)) state_d = S_START;
         end
         S_START: if (cnt_q == CNT_W'(START_W - 1)) state_d = S_WAIT;
         S_WAIT: begin
            got_d = 1'b0;
            if (int_p) state_d = S_DRAIN;
`ifdef TDC_SHOT_CTRL_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
               err_d = 1'b1;
               state_d = S_END;
            end
`endif
         end
         S_DRAIN: begin
            if (hs) begin
               got_d = 1'b1;
               hits_d = sat_inc(hits_q);
               // strict > keeps the earliest beat on ties; the very first beat always seeds best
               if (bus.tdc_oint > best_int_q || hits_q == '0) begin
                  best_tof_d = bus.tdc_odata;
                  best_int_d = bus.tdc_oint;
               end
               if (bus.tdc_olast) state_d = S_END;
            end else if (!got_q && cnt_q == CNT_W'(DRAIN_WIN - 1)) state_d = S_END;
         end
         S_END: begin
            shot_d = shot_q + 8'd1;
            if (9'(shot_q) + 9'd1 < 9'(shots_eff)) state_d = S_ARM;
            else begin
               state_d = S_EMIT;
               m_valid_d = 1'b1;
               m_tof_d = best_tof_q;
               m_int_d = best_int_q;
               m_hits_d = hits_q;
            end
         end
         S_EMIT: if (bus.m_ready) begin
            m_valid_d = 1'b0;
            state_d = en_i ? S_ARM : S_IDLE;
            clr = en_i;
         end
         default: state_d = S_IDLE;
      endcase
      if (clr) begin
         shot_d = '0;
         hits_d = '0;
         best_tof_d = '0;
         best_int_d = '0;
      end
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      start_d = state_d == S_START;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         shot_q <= '0;
         hits_q <= '0;
         best_tof_q <= '0;
         best_int_q <= '0;
         range_q <= '0;
         got_q <= 1'b0;
         start_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_tof_q <= '0;
         m_int_q <= '0;
         m_hits_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         shot_q <= shot_d;
         hits_q <= hits_d;
         best_tof_q <= best_tof_d;
         best_int_q <= best_int_d;
         range_q <= range_d;
         got_q <= got_d;
         start_q <= start_d;
         m_valid_q <= m_valid_d;
         m_tof_q <= m_tof_d;
         m_int_q <= m_int_d;
         m_hits_q <= m_hits_d;
         err_q <= err_d;
      end
endmodule

// File: tb/tb_tdc_shot_ctrl.sv
// tb_tdc_shot_ctrl: randomized core model driving tdc_shot_ctrl, checked against a per-pixel best-return model.
module tb_tdc_shot_ctrl;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, tint = 1'b0, busy, err;
   logic [7:0]  shots = 8'd1;
   logic [14:0] rng = '0;
   int n_cmp = 0, n_bad = 0;
   int nb[8];
   logic [9:0] bt[8][8];
   logic [4:0] bi[8][8];
   tdc_shot_ctrl_if bus();
   tdc_shot_ctrl dut (
      .clk(clk), .rst(rst), .en_i(en), .cfg_shots_i(shots), .cfg_range_i(rng),
      .tdc_int_i(tint), .bus(bus), .busy_o(busy), .err_tmo_o(err)
   );
   always #2 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus.tdc_start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask
   task automatic wait_mvalid(input int lim, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < lim; k++) begin
         if (bus.m_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask
   task automatic pulse_int();
      tint = 1'b1;
      tick(3);
      tint = 1'b0;
   endtask
   task automatic send_beat(input logic [9:0] t, input logic [4:0] i, input bit last, output bit ok);
      bit g;
      bus.tdc_ovalid = 1'b1;
      bus.tdc_odata = t;
      bus.tdc_oint = i;
      bus.tdc_olast = last;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         g = bus.tdc_oready;
         @(posedge clk);
         #1;
         if (g) begin
            ok = 1'b1;
            break;
         end
      end
      bus.tdc_ovalid = 1'b0;
      bus.tdc_olast = 1'b0;
   endtask
   task automatic run_pixel(input logic [7:0] cfg, input int hold, input bit drop_en, input string nm);
      int ns, hits, w;
      logic [9:0] etof;
      logic [4:0] eint;
      bit ok;
      ns = (cfg == 0) ? 1 : int'(cfg);
      hits = 0;
      etof = '0;
      eint = '0;
      for (int s = 0; s < ns; s++)
         for (int b = 0; b < nb[s]; b++) begin
            if (hits == 0 || bi[s][b] > eint) begin
               etof = bt[s][b];
               eint = bi[s][b];
            end
            hits++;
         end
      shots = cfg;
      en = 1'b1;
      for (int s = 0; s < ns; s++) begin
         rng = 15'($urandom);
         wait_start(ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL %s start%0d: no tdc_start seen, required one", nm, s);
         end
         n_cmp++;
         if (bus.tdc_range !== rng) begin
            n_bad++;
            $display("FAIL %s range%0d: got %h required %h", nm, s, bus.tdc_range, rng);
         end
         w = 0;
         while (bus.tdc_start && w < 10) begin
            w++;
            tick();
         end
         n_cmp++;
         if (w != 2) begin
            n_bad++;
            $display("FAIL %s start_width%0d: got %0d required 2", nm, s, w);
         end
         if (drop_en && s == 0) en = 1'b0;
         tick($urandom_range(0, 5));
         pulse_int();
         for (int b = 0; b < nb[s]; b++) begin
            if (b > 0) tick($urandom_range(0, 2));
            send_beat(bt[s][b], bi[s][b], b == nb[s] - 1, ok);
            n_cmp++;
            if (!ok) begin
               n_bad++;
               $display("FAIL %s beat%0d.%0d: no handshake, required one", nm, s, b);
            end
         end
      end
      wait_mvalid(200, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s m_valid: got 0 required 1", nm);
      end
      n_cmp++;
      if (bus.m_tof !== etof || bus.m_int !== eint || bus.m_hits !== 10'(hits)) begin
         n_bad++;
         $display("FAIL %s result: got tof=%h int=%0d hits=%0d required tof=%h int=%0d hits=%0d",
                  nm, bus.m_tof, bus.m_int, bus.m_hits, etof, eint, hits);
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         n_cmp++;
         if (bus.m_valid !== 1'b1 || bus.m_tof !== etof || bus.m_int !== eint || bus.m_hits !== 10'(hits)
             || bus.tdc_oready !== 1'b0 || bus.tdc_start !== 1'b0) begin
            n_bad++;
            $display("FAIL %s hold%0d: got v=%b tof=%h int=%0d hits=%0d ordy=%b start=%b required v=1 tof=%h int=%0d hits=%0d ordy=0 start=0",
                     nm, h, bus.m_valid, bus.m_tof, bus.m_int, bus.m_hits, bus.tdc_oready, bus.tdc_start, etof, eint, hits);
         end
      end
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      n_cmp++;
      if (bus.m_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s m_valid_after_hs: got %b required 0", nm, bus.m_valid);
      end
      if (drop_en) begin
         n_cmp++;
         if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_after_emit: got %b required 0", nm, busy);
         end
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      n_cmp++;
      if ({bus.tdc_start, bus.tdc_range, bus.tdc_oready, bus.m_valid, bus.m_tof, bus.m_int, bus.m_hits, busy, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got start=%b range=%h ordy=%b v=%b hits=%0d busy=%b err=%b required all 0",
                  bus.tdc_start, bus.tdc_range, bus.tdc_oready, bus.m_valid, bus.m_hits, busy, err);
      end
      rst = 1'b0;
      tick(5);
      n_cmp++;
      if (busy !== 1'b0 || bus.tdc_start !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_without_en: got busy=%b start=%b required 0 0", busy, bus.tdc_start);
      end
   endtask
   task automatic test_single();
      nb[0] = 1;
      bt[0][0] = 10'h123;
      bi[0][0] = 5'd7;
      run_pixel(8'd1, 0, 1'b1, "single");
   endtask
   task automatic test_multi_shot();
      nb[0] = 3;
      nb[1] = 1;
      nb[2] = 0;
      bt[0][0] = 10'h010; bi[0][0] = 5'd3;
      bt[0][1] = 10'h011; bi[0][1] = 5'd9;
      bt[0][2] = 10'h012; bi[0][2] = 5'd9;
      bt[1][0] = 10'h020; bi[1][0] = 5'd5;
      run_pixel(8'd3, 0, 1'b1, "multi_shot");
   endtask
   task automatic test_zero_hits();
      nb[0] = 0;
      run_pixel(8'd1, 0, 1'b1, "zero_hits");
   endtask
   task automatic test_emit_hold();
      nb[0] = 2;
      bt[0][0] = 10'h2aa; bi[0][0] = 5'd1;
      bt[0][1] = 10'h155; bi[0][1] = 5'd30;
      run_pixel(8'd0, 20, 1'b1, "emit_hold");
   endtask
   task automatic test_random();
      int ns;
      for (int p = 0; p < 8; p++) begin
         ns = $urandom_range(1, 4);
         for (int s = 0; s < ns; s++) begin
            nb[s] = $urandom_range(0, 4);
            for (int b = 0; b < nb[s]; b++) begin
               bt[s][b] = 10'($urandom);
               bi[s][b] = 5'($urandom_range(0, 7));
            end
         end
         run_pixel(8'(ns), $urandom_range(0, 3), p == 7 || $urandom_range(0, 1) == 1, $sformatf("random%0d", p));
      end
   endtask
   task automatic test_timeout();
      bit ok;
      shots = 8'd1;
      en = 1'b1;
      wait_start(ok);
      en = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL timeout_start: no tdc_start seen, required one");
      end
`ifdef TDC_SHOT_CTRL_TIMEOUT_EN
      wait_mvalid(4400, ok);
      n_cmp++;
      if (!ok || err !== 1'b1 || bus.m_hits !== '0 || bus.m_tof !== '0 || bus.m_int !== '0) begin
         n_bad++;
         $display("FAIL timeout_emit: got v=%b err=%b hits=%0d tof=%h int=%0d required v=1 err=1 hits=0 tof=0 int=0",
                  bus.m_valid, err, bus.m_hits, bus.m_tof, bus.m_int);
      end
`else
      tick(4400);
      n_cmp++;
      if (busy !== 1'b1 || bus.m_valid !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL no_timeout_wait: got busy=%b v=%b err=%b required 1 0 0", busy, bus.m_valid, err);
      end
      pulse_int();
      wait_mvalid(100, ok);
      n_cmp++;
      if (!ok || bus.m_hits !== '0 || bus.m_tof !== '0 || bus.m_int !== '0) begin
         n_bad++;
         $display("FAIL late_int_emit: got v=%b hits=%0d tof=%h int=%0d required v=1 hits=0 tof=0 int=0",
                  bus.m_valid, bus.m_hits, bus.m_tof, bus.m_int);
      end
`endif
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
   endtask
   task automatic test_reset_drain();
      bit ok;
      shots = 8'd1;
      en = 1'b1;
      wait_start(ok);
      tick(3);
      pulse_int();
      send_beat(10'h3ff, 5'd31, 1'b0, ok);
      n_cmp++;
      if (!ok || bus.tdc_oready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_drain_setup: got hs=%b ordy=%b required 1 1", ok, bus.tdc_oready);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.tdc_start, bus.tdc_range, bus.tdc_oready, bus.m_valid, bus.m_tof, bus.m_int, bus.m_hits, busy, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_in_drain: got start=%b range=%h ordy=%b v=%b hits=%0d busy=%b err=%b required all 0",
                  bus.tdc_start, bus.tdc_range, bus.tdc_oready, bus.m_valid, bus.m_hits, busy, err);
      end
      tick();
      rst = 1'b0;
      nb[0] = 1;
      bt[0][0] = 10'h055;
      bi[0][0] = 5'd4;
      run_pixel(8'd1, 0, 1'b1, "after_reset");
   endtask
   initial begin
      bus.tdc_ovalid = 1'b0;
      bus.tdc_odata = '0;
      bus.tdc_oint = '0;
      bus.tdc_olast = 1'b0;
      bus.m_ready = 1'b0;
      test_reset();
      test_single();
      test_multi_shot();
      test_zero_hits();
      test_emit_hold();
      test_random();
      test_timeout();
      test_reset_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
